// File: rtl/hdr_frame_fetcher.sv
// hdr_frame_fetcher
// Read-side master that fills the HDR pixel buffer from SDRAM. For every frame it
// fetches one burst each from the high, mid and low exposure buffers at the same
// offset. It stages the high and mid bursts locally, then emits aligned triplets
// while the low burst streams in.
//
// Ports:
//   clk_133M, rst_133M         sole clock, synchronous active-high reset
//   frame_start                one-cycle pulse, starts a frame fetch when idle
//   buf_afull                  pixel FIFO cannot take another burst
//   mem_rd_req/addr/ack        SDRAM controller read request handshake
//   mem_rd_data/data_valid     returned read words
//   data_high/mid/low          aligned triplet, written when rd_valid is high
//   rd_valid                   FIFO write enable
//   frame_done                 one-cycle pulse after the last triplet of a frame
//   busy                       frame fetch in progress
module hdr_frame_fetcher #(
    parameter int unsigned       BURST_LEN   = 8,
    parameter int unsigned       FRAME_WORDS = 38400,
    parameter int unsigned       ADDR_W      = 24,
    parameter logic [ADDR_W-1:0] BASE_HIGH   = 24'h000000,
    parameter logic [ADDR_W-1:0] BASE_MID    = 24'h010000,
    parameter logic [ADDR_W-1:0] BASE_LOW    = 24'h020000
) (
    input  logic              clk_133M,
    input  logic              rst_133M,
    input  logic              frame_start,
    input  logic              buf_afull,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_ack,
    input  logic [127:0]      mem_rd_data,
    input  logic              mem_rd_data_valid,
    output logic [127:0]      data_high,
    output logic [127:0]      data_mid,
    output logic [127:0]      data_low,
    output logic              rd_valid,
    output logic              frame_done,
    output logic              busy
);

    localparam int unsigned       CNT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0]  LAST_WORD  = CNT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] FRAME_END  = ADDR_W'(FRAME_WORDS);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_CHECK  = 4'd1;
    localparam logic [3:0] S_REQ_H  = 4'd2;
    localparam logic [3:0] S_WAIT_H = 4'd3;
    localparam logic [3:0] S_REQ_M  = 4'd4;
    localparam logic [3:0] S_WAIT_M = 4'd5;
    localparam logic [3:0] S_REQ_L  = 4'd6;
    localparam logic [3:0] S_WAIT_L = 4'd7;
    localparam logic [3:0] S_DONE   = 4'd8;

    logic [3:0]        state;
    logic [3:0]        next_state;
    logic [ADDR_W-1:0] offset;
    logic [CNT_W-1:0]  wcnt;
    logic [127:0]      hbuf [BURST_LEN];
    logic [127:0]      mbuf [BURST_LEN];

    logic              in_wait_c;
    logic              last_word_c;
    logic              req_c;
    logic [ADDR_W-1:0] addr_c;
    logic [ADDR_W-1:0] offset_inc_c;

    assign in_wait_c    = (state == S_WAIT_H) || (state == S_WAIT_M) || (state == S_WAIT_L);
    assign last_word_c  = in_wait_c && mem_rd_data_valid && (wcnt == LAST_WORD);
    assign offset_inc_c = offset + BURST_STEP;

    // State register
    always_ff @(posedge clk_133M) begin
        if (rst_133M) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; the request registers are loaded from the state being
    // entered so mem_rd_req is already high in the first REQ_x cycle.
    always_comb begin
        next_state = state;
        req_c      = 1'b0;
        addr_c     = mem_rd_addr;

        case (state)
            S_IDLE:   if (frame_start)       next_state = S_CHECK;
            S_CHECK:  if (!buf_afull)        next_state = S_REQ_H;
            S_REQ_H:  if (mem_rd_ack)        next_state = S_WAIT_H;
            S_WAIT_H: if (last_word_c)       next_state = S_REQ_M;
            S_REQ_M:  if (mem_rd_ack)        next_state = S_WAIT_M;
            S_WAIT_M: if (last_word_c)       next_state = S_REQ_L;
            S_REQ_L:  if (mem_rd_ack)        next_state = S_WAIT_L;
            S_WAIT_L: begin
                if (last_word_c) begin
                    next_state = (offset_inc_c == FRAME_END) ? S_DONE : S_CHECK;
                end
            end
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase

        case (next_state)
            S_REQ_H: begin
                req_c  = 1'b1;
                addr_c = BASE_HIGH + offset;
            end
            S_REQ_M: begin
                req_c  = 1'b1;
                addr_c = BASE_MID + offset;
            end
            S_REQ_L: begin
                req_c  = 1'b1;
                addr_c = BASE_LOW + offset;
            end
            default: begin
                req_c  = 1'b0;
                addr_c = mem_rd_addr;
            end
        endcase
    end

    // Registered outputs, offset and word counter
    always_ff @(posedge clk_133M) begin
        if (rst_133M) begin
            offset      <= '0;
            wcnt        <= '0;
            mem_rd_req  <= 1'b0;
            mem_rd_addr <= '0;
            data_high   <= '0;
            data_mid    <= '0;
            data_low    <= '0;
            rd_valid    <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            mem_rd_req  <= req_c;
            mem_rd_addr <= addr_c;
            rd_valid    <= 1'b0;
            frame_done  <= 1'b0;

            // Power-of-two burst length lets the counter wrap on its own.
            if (in_wait_c && mem_rd_data_valid) begin
                wcnt <= wcnt + CNT_W'(1);
            end

            if ((state == S_WAIT_L) && mem_rd_data_valid) begin
                rd_valid  <= 1'b1;
                data_high <= hbuf[wcnt];
                data_mid  <= mbuf[wcnt];
                data_low  <= mem_rd_data;
            end

            if ((state == S_WAIT_L) && last_word_c) begin
                offset <= offset_inc_c;
            end

            if ((state == S_IDLE) && frame_start) begin
                offset <= '0;
                busy   <= 1'b1;
            end

            if (state == S_DONE) begin
                frame_done <= 1'b1;
                busy       <= 1'b0;
                offset     <= '0;
            end
        end
    end

    // Staging buffers for the high and mid bursts
    always_ff @(posedge clk_133M) begin
        if ((state == S_WAIT_H) && mem_rd_data_valid) begin
            hbuf[wcnt] <= mem_rd_data;
        end
        if ((state == S_WAIT_M) && mem_rd_data_valid) begin
            mbuf[wcnt] <= mem_rd_data;
        end
    end

endmodule
